// File: rtl/qeciphy_crc_framer.sv
// Transmit frame sequencer: forwards 64-bit payload words and appends a
// CRC-16/IBM-3740 trailer (tag, sequence number, CRC) after every frame.

module qeciphy_crc16_engine (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  logic [63:0] i_data,
    output logic [15:0] o_crc
);

    logic [15:0] crc_reg;
    logic [15:0] crc_next;

    // One shift/xor stage per data bit, word bit 63 entering first.
    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_bit
            logic [15:0] cur;
            logic [15:0] nxt;
            if (gi == 0) begin : g_first
                assign cur = crc_reg;
            end else begin : g_rest
                assign cur = g_bit[gi-1].nxt;
            end
            assign nxt = {cur[14:0], 1'b0} ^ ({16{cur[15] ^ i_data[63-gi]}} & 16'h1021);
        end
    endgenerate

    assign crc_next = g_bit[63].nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_reg <= 16'hFFFF;
        end else if (i_valid) begin
            crc_reg <= crc_next;
        end
    end

    assign o_crc = crc_reg;

endmodule

module qeciphy_crc_framer #(
    parameter int unsigned FRAME_WORDS = 8,
    parameter logic [7:0]  TRAILER_TAG = 8'hC3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_enable,
    input  logic [63:0] s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [63:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic [15:0] o_frame_seq,
    output logic        o_busy
);

    localparam logic [15:0] LAST_IDX = 16'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_TRAILER
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] count_reg, count_next;
    logic [15:0] seq_reg, seq_next;
    logic [63:0] tdata_reg, tdata_next;
    logic        tvalid_reg, tvalid_next;
    logic        tlast_reg, tlast_next;

    logic        slot_free;
    logic        accept;
    logic        crc_clear;
    logic        crc_rst_n;
    logic [15:0] crc_value;

    assign slot_free = ~tvalid_reg | m_tready;
    assign s_tready  = (state_reg == ST_DATA) & slot_free;
    assign accept    = s_tvalid & s_tready;
    assign crc_rst_n = rst_n & ~crc_clear;

    qeciphy_crc16_engine u_crc (
        .clk     (clk),
        .rst_n   (crc_rst_n),
        .i_valid (accept),
        .i_data  (s_tdata),
        .o_crc   (crc_value)
    );

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        seq_next    = seq_reg;
        tdata_next  = tdata_reg;
        tlast_next  = tlast_reg;
        tvalid_next = tvalid_reg & ~m_tready;
        crc_clear   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (i_enable) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                // An accepted word always wins over a frame-boundary disable.
                if (accept) begin
                    tdata_next  = s_tdata;
                    tlast_next  = 1'b0;
                    tvalid_next = 1'b1;
                    if (count_reg == LAST_IDX) begin
                        count_next = 16'd0;
                        state_next = ST_TRAILER;
                    end else begin
                        count_next = count_reg + 16'd1;
                    end
                end else if ((count_reg == 16'd0) && !i_enable) begin
                    state_next = ST_IDLE;
                end
            end
            ST_TRAILER: begin
                // CRC register already holds the complete frame checksum here.
                if (slot_free) begin
                    tdata_next  = {TRAILER_TAG, 24'h000000, seq_reg, crc_value};
                    tlast_next  = 1'b1;
                    tvalid_next = 1'b1;
                    crc_clear   = 1'b1;
                    seq_next    = seq_reg + 16'd1;
                    state_next  = i_enable ? ST_DATA : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            count_reg  <= 16'd0;
            seq_reg    <= 16'd0;
            tdata_reg  <= 64'd0;
            tvalid_reg <= 1'b0;
            tlast_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            seq_reg    <= seq_next;
            tdata_reg  <= tdata_next;
            tvalid_reg <= tvalid_next;
            tlast_reg  <= tlast_next;
        end
    end

    assign m_tdata     = tdata_reg;
    assign m_tvalid    = tvalid_reg;
    assign m_tlast     = tlast_reg;
    assign o_frame_seq = seq_reg;
    assign o_busy      = (state_reg == ST_DATA) || (state_reg == ST_TRAILER);

endmodule

// File: doc/qeciphy_crc_framer.md
Name: qeciphy_crc_framer

Overview:
- Transmit-side frame sequencer around the CRC-16/IBM-3740 64-bit parallel engine (poly 0x1021, init 0xFFFF, no reflection, xorout 0).
- Accepts a 64-bit data word stream and forwards it unchanged.
- After every FRAME_WORDS data words, inserts one trailer word carrying the frame CRC and a sequence number.
- Re-initialises the CRC engine for each frame. Sits between the QEC payload source and the PHY TX gearbox.

Parameters:
- FRAME_WORDS, 8, data words per frame, legal range 1..65535.
- TRAILER_TAG, 8'hC3, constant placed in trailer bits [63:56].

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_enable  in  1  framing enable; sampled only at frame boundaries
- s_tdata  in  64  input data word
- s_tvalid  in  1  input word valid
- s_tready  out  1  input word accepted when s_tvalid & s_tready
- m_tdata  out  64  output word (data or trailer)
- m_tvalid  out  1  output valid
- m_tready  in  1  downstream ready
- m_tlast  out  1  high with the trailer word
- o_frame_seq  out  16  number of trailers emitted, modulo 2^16
- o_busy  out  1  high in DATA or TRAILER state

Behaviour:
- Reset values: m_tvalid=0, m_tdata=0, m_tlast=0, s_tready=0, o_frame_seq=0, o_busy=0, state=IDLE, word count=0, CRC engine=0xFFFF.
- Output stage:
  - Single register; slot_free = ~m_tvalid | m_tready.
  - m_tvalid/m_tdata/m_tlast hold stable while m_tvalid & ~m_tready.
  - Latency from input acceptance to m_tvalid is 1 cycle.
- s_tready = (state==DATA) & slot_free. It is combinational on m_tready; there is no combinational path from s_tvalid.
- CRC engine:
  - i_valid = s_tvalid & s_tready; i_data = s_tdata.
  - The engine's reset input is driven with rst_n & ~crc_clear.
  - crc_clear pulses for one cycle when the trailer is loaded into the output register, so the engine holds 0xFFFF on the next cycle.
- States:
  - IDLE: no acceptance. Move to DATA when i_enable=1.
  - DATA: each accepted word is loaded into the output register with m_tlast=0 and increments the word count.
    - On accepting word FRAME_WORDS-1, go to TRAILER and clear the word count.
    - If word count==0 and i_enable=0, go to IDLE.
    - i_enable=0 mid-frame is ignored; the frame always completes.
  - TRAILER: s_tready=0. The engine output already holds the final frame CRC (registered the previous cycle). When slot_free, the block does all of the following in one cycle:
    - loads m_tdata = {TRAILER_TAG, 24'h0, o_frame_seq, crc} with m_tlast=1;
    - pulses crc_clear;
    - increments o_frame_seq (0xFFFF wraps to 0x0000);
    - goes to DATA if i_enable=1, else IDLE.
- Data content never affects framing. s_tdata is forwarded bit-exact.
- Backpressure: with m_tready held low, at most one word is in the output register and no input is accepted. CRC state is unchanged while stalled.
- FRAME_WORDS=1: the state alternates DATA and TRAILER; every data word is followed by a trailer.
- Reset mid-frame:
  - the partial frame is discarded;
  - a pending output word is dropped (m_tvalid=0 the next cycle);
  - the CRC returns to 0xFFFF and the sequence returns to 0.
- Throughput: FRAME_WORDS/(FRAME_WORDS+1) words per cycle with m_tready held high.

Test Plan:
- FRAME_WORDS=1, i_enable=1, m_tready=1, send s_tdata=0.
  - Output 0x0000_0000_0000_0000 (m_tlast=0), then 0xC300_0000_0000_313E (m_tlast=1).
- Same configuration, two consecutive zero words.
  - Trailers are 0xC300_0000_0000_313E and 0xC300_0000_0001_313E. This proves CRC re-initialisation and the sequence increment.
- FRAME_WORDS=8, random data, random m_tready.
  - Every 9th output has m_tlast=1 and trailer[15:0] equal to the serial bitwise reference CRC (init 0xFFFF, MSB-first, word bit 63 first) of the 8 words.
  - No data word is lost or duplicated.
  - m_tdata is stable while stalled.
- Drop i_enable after word 3 of an 8-word frame.
  - Words 4..7 are still accepted and a trailer is emitted.
  - The state then goes to IDLE with s_tready=0 and o_busy=0.
- Assert rst_n=0 for 1 cycle after word 5 with m_tvalid=1 and m_tready=0.
  - Next cycle: m_tvalid=0 and o_frame_seq=0.
  - A following full zero-word frame with FRAME_WORDS=1 yields CRC 0x313E.
- Preload 65535 frames (FRAME_WORDS=1).
  - The trailer carries seq 0xFFFF, then o_frame_seq wraps to 0x0000 and the next trailer carries 0x0000.
